dmem_access: RTL and testbench
==============================

// Module: dmem_access
// PURPOSE
// - Data-memory stage between execute and writeback. Takes one load/store from execute and runs a req/rsp handshake to data memory.
// - Formats store data/strobes; aligns and sign/zero-extends load data.
// - Drives the dmemToWriteback fields (load_active, next_rd, next_rd_value) and stalls the pipeline while a memory op is in flight.
// PARAMETERS
// - ADDR_W       32   byte-address width of ex_addr / mem_req_addr
// - TIMEOUT_CYC  255  cycles in REQ+WAIT before the access aborts with mem_err (8-bit counter, >=2)
// PORTS
// - clk            in   1       clock; all state on posedge
// - rst            in   1       asynchronous, active-high reset
// - ex_valid       in   1       execute presents a memory op this cycle
// - ex_we          in   1       1=store, 0=load
// - ex_funct3      in   3       RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
// - ex_addr        in   ADDR_W  effective byte address
// - ex_wdata       in   32      store source (rs2)
// - ex_rd          in   5       load destination register
// - stall          out  1       hold execute and all earlier stages
// - mem_req_valid  out  1       memory request valid
// - mem_req_ready  in   1       memory accepts request
// - mem_req_we     out  1       request is write
// - mem_req_addr   out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
// - mem_req_wdata  out  32      lane-replicated store data
// - mem_req_wstrb  out  4       byte enables (0000 on reads)
// - mem_rsp_valid  in   1       response valid (read data, or write ack)
// - mem_rsp_rdata  in   32      read data word
// - load_active    out  1       writeback takes next_rd/next_rd_value this cycle
// - next_rd        out  5       destination register
// - next_rd_value  out  32      extended load result
// - mem_err        out  1       one-cycle pulse: misaligned, illegal funct3, or timeout
// BEHAVIOUR
// - States: IDLE, REQ, WAIT, DONE. Reset (async) -> IDLE; counter=0; every output 0. In-flight bus transaction is abandoned.
// - IDLE & ex_valid:
//   - capture op regs; stall=1 combinationally this cycle.
//   - Legal & aligned -> REQ; else (W addr[1:0]!=0, H addr[0]!=0, illegal funct3) -> DONE with err flag set, no bus access.
// - REQ: mem_req_valid=1; outputs stable until mem_req_ready; handshake -> WAIT.
// - WAIT: mem_rsp_valid sampled only here, never in the handshake cycle; capture rdata -> DONE.
// - DONE: exactly one cycle, stall=0, then -> IDLE.
//   - load_active=1 iff load & no error & rd!=0.
//   - mem_err=1 iff err flag set; stores never assert load_active.
// - stall = (state==REQ|WAIT) | (state==IDLE & ex_valid). A new op is accepted no earlier than the cycle after DONE.
//   - Minimum load latency: accept -> DONE = 3 cycles when ready and rsp arrive immediately.
// - Timeout: counter clears on accept and increments each REQ/WAIT cycle.
//   - At TIMEOUT_CYC -> DONE with mem_err=1, load_active=0.
//   - A late mem_rsp_valid arriving in IDLE/DONE is ignored.
// - Stores:
//   - SB: wstrb=0001<<a[1:0], wdata={4{b}}.
//   - SH: wstrb=0011<<{a[1],0}, wdata={2{h}}.
//   - SW: 1111, wdata=rs2.
// - Loads: lane = rdata>>(8*a[1:0]). B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged. Result registered at WAIT->DONE.
// - When load_active=0: next_rd and next_rd_value hold their last values.
// STRUCTURE
// - dmem_pkg: funct3 size constants, dmem_state_t enum, TIMEOUT counter width.
// - Sub-module load_align (combinational): rdata, addr[1:0], funct3 -> 32-bit extended value.
// - Store formatting and the FSM stay inline.
// TESTING
// - LB a=0x1003, rdata=0x80FF_0000, ready/rsp immediate
//   -> DONE 3 cycles after accept; load_active=1, next_rd_value=0xFFFF_FF80.
// - SH a=0x2002, rs2=0x1234_ABCD
//   -> wstrb=1100, wdata=0xABCD_ABCD, addr=0x2000, load_active stays 0.
// - LW a=0x3001 -> no mem_req_valid; mem_err pulses 1 cycle; load_active=0; stall released in DONE.
// - LHU, ready held 0 for 5 cycles then rsp 4 cycles later
//   -> req fields stable throughout; stall high until DONE; zero-extended result.
// - TIMEOUT_CYC=4, no ready -> mem_err at DONE after 4 REQ cycles; a late rsp_valid in IDLE is ignored.
// - rst asserted mid-WAIT -> immediately IDLE, all outputs 0; next LW completes normally. LW with rd=0 -> load_active=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access stage.
// Size codes, FSM state encoding and timeout counter width.
package dmem_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } dmem_state_t;

endpackage

// File: rtl/dmem_access_load_align.sv
// Load data alignment: selects the addressed lane of the read word
// and sign- or zero-extends it according to the size code.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] value_o
);

    logic [31:0] lane;

    // shift addressed byte to bit 0, then extend by size code
    always_comb begin
        lane    = rdata_i >> {off_i, 3'b000};
        value_o = lane;
        unique case (funct3_i)
            F3_B:    value_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    value_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   value_o = {24'd0, lane[7:0]};
            F3_HU:   value_o = {16'd0, lane[15:0]};
            default: value_o = lane;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// Data-memory stage: one load/store at a time over a req/rsp bus,
// with store formatting, load extension, timeout and pipeline stall.
module dmem_access
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata,
    output logic              load_active,
    output logic [4:0]        next_rd,
    output logic [31:0]       next_rd_value,
    output logic              mem_err
);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [4:0]        nrd_q, nrd_d;
    logic [31:0]       nval_q, nval_d;

    logic              legal;
    logic              aligned;
    logic [CNT_W:0]    cnt_inc;
    logic              timeout;
    logic [31:0]       ld_val;
    logic              is_req;
    logic              is_wr;
    logic [3:0]        strb;
    logic [31:0]       wd;

    load_align u_align (
        .rdata_i  (mem_rsp_rdata),
        .off_i    (addr_q[1:0]),
        .funct3_i (f3_q),
        .value_o  (ld_val)
    );

    assign cnt_inc = {1'b0, cnt_q} + 1'b1;
    assign timeout = int'(cnt_inc) >= TIMEOUT_CYC;

    // classify the incoming op: legal size code and natural alignment
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        unique case (ex_funct3)
            F3_B:  legal = 1'b1;
            F3_H: begin
                legal   = 1'b1;
                aligned = ~ex_addr[0];
            end
            F3_W: begin
                legal   = 1'b1;
                aligned = (ex_addr[1:0] == 2'b00);
            end
            F3_BU: legal = ~ex_we;
            F3_HU: begin
                legal   = ~ex_we;
                aligned = ~ex_addr[0];
            end
            default: legal = 1'b0;
        endcase
    end

    // next-state logic: capture, handshake, response, timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        nrd_d   = nrd_q;
        nval_d  = nval_q;
        unique case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    we_d    = ex_we;
                    f3_d    = ex_funct3;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    rd_d    = ex_rd;
                    cnt_d   = '0;
                    err_d   = ~(legal & aligned);
                    state_d = (legal & aligned) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    if (!we_q && rd_q != 5'd0) begin
                        nrd_d  = rd_q;
                        nval_d = ld_val;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and captured-operation registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            nrd_q   <= 5'd0;
            nval_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            nrd_q   <= nrd_d;
            nval_q  <= nval_d;
        end
    end

    // store lane replication and byte enables
    always_comb begin
        strb = 4'b0000;
        wd   = '0;
        unique case (f3_q[1:0])
            2'b00: begin
                strb = 4'b0001 << addr_q[1:0];
                wd   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb = 4'b0011 << {addr_q[1], 1'b0};
                wd   = {2{wdata_q[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                wd   = wdata_q;
            end
        endcase
    end

    assign is_req = (state_q == S_REQ);
    assign is_wr  = is_req & we_q;

    assign stall = (state_q == S_REQ) | (state_q == S_WAIT)
                 | ((state_q == S_IDLE) & ex_valid);

    assign mem_req_valid = is_req;
    assign mem_req_we    = is_wr;
    assign mem_req_addr  = is_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_req_wstrb = is_wr ? strb : 4'b0000;
    assign mem_req_wdata = is_wr ? wd : 32'd0;

    assign load_active = (state_q == S_DONE) & ~we_q & ~err_q
                       & (rd_q != 5'd0);
    assign mem_err     = (state_q == S_DONE) & err_q;
    assign next_rd       = nrd_q;
    assign next_rd_value = nval_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access with a bus responder and a
// scoreboard queue of expected writeback results.
module tb_dmem_access;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        load_active;
    logic [4:0]  next_rd;
    logic [31:0] next_rd_value;
    logic        mem_err;

    logic        ex_valid2;
    logic        stall2;
    logic        mem_req_valid2;
    logic        mem_req_ready2;
    logic        mem_req_we2;
    logic [31:0] mem_req_addr2;
    logic [31:0] mem_req_wdata2;
    logic [3:0]  mem_req_wstrb2;
    logic        mem_rsp_valid2;
    logic        load_active2;
    logic [4:0]  next_rd2;
    logic [31:0] next_rd_value2;
    logic        mem_err2;

    typedef struct {
        string       tag;
        logic        la;
        logic        err;
        logic [4:0]  rd;
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          ncmp;
    int          nfail;
    logic [4:0]  last_rd;
    logic [31:0] last_val;

    dmem_access dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_we         (ex_we),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .ex_rd         (ex_rd),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .load_active   (load_active),
        .next_rd       (next_rd),
        .next_rd_value (next_rd_value),
        .mem_err       (mem_err)
    );

    dmem_access #(.TIMEOUT_CYC(4)) dut_to (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid2),
        .ex_we         (ex_we),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .ex_rd         (ex_rd),
        .stall         (stall2),
        .mem_req_valid (mem_req_valid2),
        .mem_req_ready (mem_req_ready2),
        .mem_req_we    (mem_req_we2),
        .mem_req_addr  (mem_req_addr2),
        .mem_req_wdata (mem_req_wdata2),
        .mem_req_wstrb (mem_req_wstrb2),
        .mem_rsp_valid (mem_rsp_valid2),
        .mem_rsp_rdata (mem_rsp_rdata),
        .load_active   (load_active2),
        .next_rd       (next_rd2),
        .next_rd_value (next_rd_value2),
        .mem_err       (mem_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(
        input string       tag,
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [4:0]  rd,
        input logic [31:0] rdata,
        input int          rdy_dly,
        input int          rsp_dly,
        input logic        bus,
        input logic [31:0] xaddr,
        input logic [3:0]  xstrb,
        input logic [31:0] xwdata,
        input logic        xla,
        input logic        xerr,
        input logic [31:0] xval,
        input int          xlat
    );
        exp_t e;
        int   rc;
        int   wc;
        int   lat;
        logic hs;
        logic done;
        e.tag = tag;
        e.la  = xla;
        e.err = xerr;
        if (xla) begin
            last_rd  = rd;
            last_val = xval;
        end
        e.rd  = last_rd;
        e.val = last_val;
        e.lat = xlat;
        sb.push_back(e);
        ex_we     = we;
        ex_funct3 = f3;
        ex_addr   = a;
        ex_wdata  = wd;
        ex_rd     = rd;
        ex_valid  = 1'b1;
        #1;
        chk({tag, "_stall_acc"}, stall, 1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_addr  = ~a;
        ex_wdata = ~wd;
        ex_rd    = ~rd;
        rc   = 0;
        wc   = 0;
        lat  = 1;
        hs   = 1'b0;
        done = 1'b0;
        while (!done && lat < 64) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                if (!bus) chk({tag, "_nobus"}, mem_req_valid, 0);
                if (mem_req_valid) begin
                    chk({tag, "_addr"}, mem_req_addr, xaddr);
                    chk({tag, "_we"}, mem_req_we, we);
                    chk({tag, "_strb"}, mem_req_wstrb, xstrb);
                    if (we) chk({tag, "_wdata"}, mem_req_wdata, xwdata);
                    mem_req_ready = (rc >= rdy_dly);
                    rc++;
                end else if (hs) begin
                    if (wc >= rsp_dly) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = rdata;
                    end
                    wc++;
                end
                @(posedge clk);
                #1;
                if (mem_req_ready) hs = 1'b1;
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
                mem_rsp_rdata = 32'h5A5A_5A5A;
                lat++;
            end
        end
        chk({tag, "_done"}, done, 1);
        e = sb.pop_front();
        chk({e.tag, "_la"}, load_active, e.la);
        chk({e.tag, "_err"}, mem_err, e.err);
        chk({e.tag, "_rd"}, next_rd, e.rd);
        chk({e.tag, "_val"}, next_rd_value, e.val);
        chk({e.tag, "_reqv_done"}, mem_req_valid, 0);
        if (e.lat > 0) chk({e.tag, "_lat"}, lat, e.lat);
        @(posedge clk);
        #1;
        chk({tag, "_err_pulse"}, mem_err, 0);
        chk({tag, "_la_pulse"}, load_active, 0);
        chk({tag, "_stall_idle"}, stall, 0);
    endtask

    initial begin
        int rq;
        int n;
        ncmp           = 0;
        nfail          = 0;
        last_rd        = 5'd0;
        last_val       = 32'd0;
        rst            = 1'b1;
        ex_valid       = 1'b0;
        ex_valid2      = 1'b0;
        ex_we          = 1'b0;
        ex_funct3      = 3'd0;
        ex_addr        = 32'd0;
        ex_wdata       = 32'd0;
        ex_rd          = 5'd0;
        mem_req_ready  = 1'b0;
        mem_req_ready2 = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_valid2 = 1'b0;
        mem_rsp_rdata  = 32'h5A5A_5A5A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_reqv", mem_req_valid, 0);
        chk("rst_la", load_active, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_rd", next_rd, 0);
        chk("rst_val", next_rd_value, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("lb_neg", 0, 3'b000, 32'h1003, 0, 5'd5, 32'h80FF_0000,
               0, 0, 1, 32'h1000, 4'b0000, 0, 1, 0, 32'hFFFF_FF80, 3);
        run_op("sh", 1, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd1, 0,
               0, 0, 1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 0, 0, 0, 3);
        run_op("lw_mis", 0, 3'b010, 32'h3001, 0, 5'd6, 0,
               0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        run_op("lhu_slow", 0, 3'b101, 32'h4002, 0, 5'd7, 32'hBEEF_1234,
               5, 4, 1, 32'h4000, 4'b0000, 0, 1, 0, 32'h0000_BEEF, 12);
        run_op("sb", 1, 3'b000, 32'h5001, 32'hAABB_CC77, 5'd2, 0,
               0, 0, 1, 32'h5000, 4'b0010, 32'h7777_7777, 0, 0, 0, 3);
        run_op("lh_neg", 0, 3'b001, 32'h6000, 0, 5'd8, 32'h0000_8001,
               0, 0, 1, 32'h6000, 4'b0000, 0, 1, 0, 32'hFFFF_8001, 3);
        run_op("lbu", 0, 3'b100, 32'h6001, 0, 5'd10, 32'h0000_F100,
               0, 0, 1, 32'h6000, 4'b0000, 0, 1, 0, 32'h0000_00F1, 3);
        run_op("sw", 1, 3'b010, 32'h7000, 32'hDEAD_BEEF, 5'd3, 0,
               1, 2, 1, 32'h7000, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 6);
        run_op("ill_f3", 0, 3'b011, 32'h8000, 0, 5'd11, 0,
               0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        run_op("ill_sbu", 1, 3'b100, 32'h8000, 0, 5'd12, 0,
               0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        run_op("sh_mis", 1, 3'b001, 32'h2001, 32'h1111_2222, 5'd13, 0,
               0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        ex_we     = 1'b0;
        ex_funct3 = 3'b010;
        ex_addr   = 32'h8000;
        ex_rd     = 5'd3;
        ex_valid2 = 1'b1;
        #1;
        chk("to_stall_acc", stall2, 1);
        @(posedge clk);
        #1;
        ex_valid2 = 1'b0;
        rq = 0;
        n  = 0;
        while (stall2 && n < 20) begin
            if (mem_req_valid2) rq++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_req_cycles", rq, 4);
        chk("to_err", mem_err2, 1);
        chk("to_la", load_active2, 0);
        chk("to_stall_done", stall2, 0);
        @(posedge clk);
        #1;
        mem_rsp_valid2 = 1'b1;
        chk("to_err_pulse", mem_err2, 0);
        @(posedge clk);
        #1;
        mem_rsp_valid2 = 1'b0;
        chk("late_rsp_stall", stall2, 0);
        chk("late_rsp_reqv", mem_req_valid2, 0);
        chk("late_rsp_err", mem_err2, 0);
        chk("late_rsp_la", load_active2, 0);
        chk("late_rsp_rd", next_rd2, 0);

        ex_we     = 1'b0;
        ex_funct3 = 3'b010;
        ex_addr   = 32'h9000;
        ex_rd     = 5'd4;
        ex_valid  = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        chk("mr_in_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        chk("mr_in_wait", stall, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_stall", stall, 0);
        chk("mr_reqv", mem_req_valid, 0);
        chk("mr_la", load_active, 0);
        chk("mr_err", mem_err, 0);
        chk("mr_rd", next_rd, 0);
        chk("mr_val", next_rd_value, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_rd  = 5'd0;
        last_val = 32'd0;
        @(posedge clk);
        #1;

        run_op("lw_post", 0, 3'b010, 32'h9004, 0, 5'd9, 32'hCAFE_F00D,
               0, 0, 1, 32'h9004, 4'b0000, 0, 1, 0, 32'hCAFE_F00D, 3);
        run_op("lw_rd0", 0, 3'b010, 32'hA000, 0, 5'd0, 32'h1111_2222,
               0, 0, 1, 32'hA000, 4'b0000, 0, 0, 0, 0, 3);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
